alu_sequencer: RTL and testbench

Two-stage issue/writeback controller that sequences the shared logic unit. It accepts one ALU request per cycle over a valid/ready handshake and drives the unit's one-hot control strobes. Each compute op gets an execute cycle (result latched into the unit's store) followed by a writeback cycle (store pushed onto bus3 or bus4). Pass-through ops complete in execute. It sits between instruction decode and the logic unit; writeback is throttled by the destination's `wr_ready`.

---
 rtl/alu_sequencer.sv | 104 ++++++++++
 tb/tb_alu_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Issue/writeback sequencer for the shared logic unit: compute ops strobe one cycle after accept and push the next; pass ops finish in E.
// Backpressure: wr_ready stalls W, which holds E and drops req_ready; optional MUL opcode enabled by ALU_SEQ_MUL_EN.
module alu_sequencer #(
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [OPW-1:0] req_op,
    input  logic           req_dst,
    input  logic           wr_ready,
    output logic [10:0]    alu_op,
    output logic           passh,
    output logic           passl,
    output logic           pass_high,
    output logic           push,
    output logic           push_high,
    output logic           done,
    output logic           err
);
    localparam logic [OPW-1:0] OP_PASS  = OPW'(0);
    localparam logic [OPW-1:0] OP_PASSW = OPW'(1);
    localparam logic [OPW-1:0] OP_DEC   = OPW'(5);
    localparam logic [OPW-1:0] OP_MUL   = OPW'(6);
    localparam logic [OPW-1:0] OP_LAST  = OPW'(12);

    logic           e_valid;
    logic [OPW-1:0] e_op;
    logic           e_dst;
    logic           w_valid;
    logic           w_dst;
    logic           err_q;

    logic e_pass, stall, dec_hold, comp_go, pass_go, e_adv, accept, req_legal;

    function automatic logic legal_op(input logic [OPW-1:0] op);
`ifdef ALU_SEQ_MUL_EN
        return op <= OP_LAST;
`else
        return (op <= OP_LAST) && (op != OP_MUL);
`endif
    endfunction

    always_comb begin
        e_pass    = (e_op == OP_PASS) || (e_op == OP_PASSW);
        stall     = w_valid && !wr_ready;
        // DEC drives bus4 during execute, so it must not overlap a bus4 push
        dec_hold  = (e_op == OP_DEC) && w_valid && w_dst;
        comp_go   = e_valid && !e_pass && !stall && !dec_hold;
        pass_go   = e_valid && e_pass && !w_valid;
        e_adv     = comp_go || (pass_go && wr_ready);
        req_ready = !e_valid || e_adv;
        accept    = req_valid && req_ready;
        req_legal = legal_op(req_op);
    end

    always_comb begin
        alu_op = '0;
        for (int i = 0; i < 11; i++) begin
            alu_op[i] = comp_go && (e_op == OPW'(i + 2));
        end
`ifndef ALU_SEQ_MUL_EN
        alu_op[4] = 1'b0;
`endif
    end

    assign passh     = pass_go && (e_op == OP_PASS);
    assign passl     = pass_go && (e_op == OP_PASS);
    assign pass_high = pass_go && (e_op == OP_PASSW);
    assign push      = w_valid && !w_dst;
    assign push_high = w_valid && w_dst;
    assign done      = wr_ready && (w_valid || pass_go);
    assign err       = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            e_valid <= 1'b0;
            e_op    <= '0;
            e_dst   <= 1'b0;
            w_valid <= 1'b0;
            w_dst   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= accept && !req_legal;

            if (comp_go) begin
                w_valid <= 1'b1;
                w_dst   <= e_dst;
            end else if (wr_ready) begin
                w_valid <= 1'b0;
            end

            // accept implies E is empty or leaving, so an illegal op simply empties E
            if (accept) begin
                e_valid <= req_legal;
                e_op    <= req_op;
                e_dst   <= req_dst;
            end else if (e_adv) begin
                e_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed timeline checks plus randomized traffic against an in-order scoreboard.
module tb_alu_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [3:0]  req_op = 4'd0;
    logic        req_dst = 1'b0;
    logic        wr_ready = 1'b0;
    logic        req_ready;
    logic [10:0] alu_op;
    logic        passh, passl, pass_high, push, push_high, done, err;

    int checks = 0;
    int failures = 0;

`ifdef ALU_SEQ_MUL_EN
    localparam int MUL = 1;
`else
    localparam int MUL = 0;
`endif

    typedef struct {
        int       id;
        logic [3:0] op;
        logic     dst;
    } rec_t;

    rec_t done_q[$];
    rec_t strobe_q[$];
    rec_t r;
    int   next_id = 0;
    int   store_id = -1;
    int   err_exp = 0;
    logic mon_en = 1'b0;

    alu_sequencer #(.OPW(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_dst(req_dst), .wr_ready(wr_ready), .alu_op(alu_op),
        .passh(passh), .passl(passl), .pass_high(pass_high), .push(push),
        .push_high(push_high), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic int legal(input logic [3:0] op);
        return int'(op <= 4'd12 && (op != 4'd6 || MUL == 1));
    endfunction

    function automatic int is_pass(input logic [3:0] op);
        return int'(op <= 4'd1);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: results must complete in acceptance order
    always @(negedge clk) begin
        if (mon_en) begin
            check("err_pulse", int'(err), err_exp);
            err_exp = 0;
            check("alu_onehot", int'($onehot0(alu_op)), 1);
            check("bus4_single", int'((int'(alu_op[3]) + int'(push_high) + int'(pass_high)) <= 1), 1);
            check("bus3_single", int'((int'(push) + int'(passh)) <= 1), 1);
            check("done_rule", int'(done), int'(wr_ready && (push || push_high || passh || pass_high)));
            if (done) begin
                if (done_q.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    r = done_q.pop_front();
                    if (is_pass(r.op) == 1) begin
                        check("pass_bus3", int'({passh, passl}), (r.op == 4'd0) ? 3 : 0);
                        check("pass_bus4", int'(pass_high), int'(r.op == 4'd1));
                    end else begin
                        check("push_dst", int'({push_high, push}), r.dst ? 2 : 1);
                        check("store_value", store_id, r.id);
                    end
                end
            end
            if (alu_op != 11'd0) begin
                if (strobe_q.size() == 0) begin
                    check("strobe_unexpected", int'(alu_op), 0);
                end else begin
                    r = strobe_q.pop_front();
                    check("strobe_op", int'(alu_op), 1 << (int'(r.op) - 2));
                    store_id = r.id;
                end
            end
            if (rst) begin
                done_q.delete();
                strobe_q.delete();
                err_exp = 0;
            end else if (req_valid && req_ready) begin
                if (legal(req_op) == 1) begin
                    r = '{next_id, req_op, req_dst};
                    next_id++;
                    done_q.push_back(r);
                    if (is_pass(req_op) == 0) strobe_q.push_back(r);
                end else begin
                    err_exp = 1;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic dst, input logic wr);
        req_valid = v;
        req_op    = op;
        req_dst   = dst;
        wr_ready  = wr;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 4'd0, 1'b0, 1'b1);
        repeat (n) cyc();
    endtask

    initial begin
        logic acc;
        int   waitc;

        drive(1'b0, 4'd0, 1'b0, 1'b1);
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        mon_en = 1'b1;
        #1;
        check("rst_req_ready", int'(req_ready), 1);
        check("rst_alu_op", int'(alu_op), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_drivers", int'(push | push_high | passh | passl | pass_high), 0);

        // single ADD
        drive(1'b1, 4'd2, 1'b0, 1'b1);
        #1 check("s1_c0_ready", int'(req_ready), 1);
        cyc(); drive(1'b0, 4'd0, 1'b0, 1'b1);
        #1 check("s1_c1_alu", int'(alu_op), 1);
        check("s1_c1_push", int'(push), 0);
        cyc(); #1;
        check("s1_c2_push", int'(push), 1);
        check("s1_c2_done", int'(done), 1);
        check("s1_c2_alu", int'(alu_op), 0);
        cyc(); #1;
        check("s1_c3_idle", int'(push | done), 0);
        idle(2);

        // ADD then SUB back to back
        drive(1'b1, 4'd2, 1'b0, 1'b1);
        cyc(); drive(1'b1, 4'd3, 1'b1, 1'b1);
        #1 check("s2_c1_alu", int'(alu_op), 1);
        check("s2_c1_ready", int'(req_ready), 1);
        cyc(); drive(1'b0, 4'd0, 1'b0, 1'b1);
        #1 check("s2_c2_alu", int'(alu_op), 2);
        check("s2_c2_push", int'(push), 1);
        check("s2_c2_done", int'(done), 1);
        cyc(); #1;
        check("s2_c3_pushh", int'(push_high), 1);
        check("s2_c3_done", int'(done), 1);
        check("s2_c3_alu", int'(alu_op), 0);
        idle(2);

        // same with wr_ready low for cycles 2..4
        drive(1'b1, 4'd2, 1'b0, 1'b1);
        cyc(); drive(1'b1, 4'd3, 1'b1, 1'b1);
        for (int c = 2; c <= 4; c++) begin
            cyc(); drive(1'b0, 4'd0, 1'b0, 1'b0);
            #1 check("s3_stall_alu", int'(alu_op), 0);
            check("s3_stall_push", int'(push), 1);
            check("s3_stall_ready", int'(req_ready), 0);
            check("s3_stall_done", int'(done), 0);
        end
        cyc(); drive(1'b0, 4'd0, 1'b0, 1'b1);
        #1 check("s3_c5_alu", int'(alu_op), 2);
        check("s3_c5_push", int'(push), 1);
        check("s3_c5_done", int'(done), 1);
        cyc(); #1;
        check("s3_c6_pushh", int'(push_high), 1);
        check("s3_c6_done", int'(done), 1);
        idle(2);

        // ADD then PASS
        drive(1'b1, 4'd2, 1'b0, 1'b1);
        cyc(); drive(1'b1, 4'd0, 1'b0, 1'b1);
        cyc(); drive(1'b0, 4'd0, 1'b0, 1'b1);
        #1 check("s4_c2_push", int'(push), 1);
        check("s4_c2_pass", int'(passh | passl), 0);
        cyc(); #1;
        check("s4_c3_pass", int'(passh & passl), 1);
        check("s4_c3_done", int'(done), 1);
        check("s4_c3_push", int'(push), 0);
        idle(2);

        // DEC behind a bus4 push waits one cycle
        drive(1'b1, 4'd3, 1'b1, 1'b1);
        cyc(); drive(1'b1, 4'd5, 1'b0, 1'b1);
        cyc(); drive(1'b0, 4'd0, 1'b0, 1'b1);
        #1 check("s5_dec_wait", int'(alu_op), 0);
        check("s5_pushh", int'(push_high), 1);
        cyc(); #1;
        check("s5_dec_go", int'(alu_op), 8);
        check("s5_no_pushh", int'(push_high), 0);
        idle(3);

        // illegal opcode and MUL
        drive(1'b1, 4'd14, 1'b0, 1'b1);
        cyc(); drive(1'b0, 4'd0, 1'b0, 1'b1);
        #1 check("s6_err14", int'(err), 1);
        check("s6_alu14", int'(alu_op), 0);
        cyc(); #1 check("s6_err14_clr", int'(err), 0);
        drive(1'b1, 4'd6, 1'b0, 1'b1);
        cyc(); drive(1'b0, 4'd0, 1'b0, 1'b1);
        #1 check("s6_err_mul", int'(err), 1 - MUL);
        check("s6_alu_mul", int'(alu_op), MUL * 16);
        cyc(); #1;
        check("s6_mul_push", int'(push), MUL);
        check("s6_err_mul_clr", int'(err), 0);
        idle(2);

        // reset with E and W both occupied
        drive(1'b1, 4'd2, 1'b0, 1'b1);
        cyc(); drive(1'b1, 4'd3, 1'b1, 1'b1);
        cyc(); drive(1'b0, 4'd0, 1'b0, 1'b0);
        rst = 1'b1;
        #1 check("s7_pre_push", int'(push), 1);
        cyc(); rst = 1'b0;
        #1 check("s7_alu", int'(alu_op), 0);
        check("s7_done", int'(done), 0);
        check("s7_ready", int'(req_ready), 1);
        check("s7_drivers", int'(push | push_high | passh | pass_high), 0);
        wr_ready = 1'b1;
        cyc(); #1;
        check("s7_no_push", int'(push | push_high | done), 0);
        idle(2);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            req_valid = 1'b1;
            req_op    = 4'($urandom_range(0, 15));
            req_dst   = 1'($urandom_range(0, 1));
            waitc = 0;
            forever begin
                wr_ready = ($urandom_range(0, 3) != 0);
                #1 acc = req_ready;
                cyc();
                if (acc) break;
                waitc++;
                if (waitc > 50) begin
                    check("accept_timeout", waitc, 0);
                    break;
                end
            end
            req_valid = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                wr_ready = ($urandom_range(0, 1) != 0);
                cyc();
            end
        end

        idle(10);
        check("drain_done_q", done_q.size(), 0);
        check("drain_strobe_q", strobe_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
